wb_initiator: RTL

Wishbone classic-cycle initiator: turns single-word requests from a local valid/ready command port into one Wishbone bus cycle each and returns read data or error on a valid/ready response port. It is the master-side counterpart of the user-area Wishbone slaves (example project, UART), used for on-chip self-test and for bridging internal engines onto the user Wishbone segment. One transfer outstanding at a time; a bounded timeout guarantees the initiator never hangs on an unresponsive address.

---
 rtl/wb_initiator_pkg.sv | 20 ++
 rtl/wb_initiator.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wb_initiator_pkg.sv
// Shared types and constants for the Wishbone classic-cycle initiator.
package wb_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int unsigned TIMEOUT_DEFAULT = 32'd255;
    localparam int unsigned WB_DW           = 32'd32;
    localparam int unsigned WB_AW           = 32'd32;
    localparam int unsigned WB_SW           = 32'd4;

    // Smallest counter width that can still hold the value TIMEOUT itself.
    function automatic int unsigned cnt_width(input int unsigned tmo);
        return $clog2(tmo + 32'd1);
    endfunction

endpackage

// File: rtl/wb_initiator.sv
// Wishbone classic-cycle initiator: one valid/ready request becomes one bus
// cycle, answered on a valid/ready response port, with a bounded ack timeout.
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [WB_SW-1:0] req_sel,
    input  logic [WB_AW-1:0] req_adr,
    input  logic [WB_DW-1:0] req_dat,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WB_DW-1:0] rsp_dat,
    output logic             rsp_err,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [WB_SW-1:0] wbm_sel_o,
    output logic [WB_AW-1:0] wbm_adr_o,
    output logic [WB_DW-1:0] wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [WB_DW-1:0] wbm_dat_i,
    output logic             busy_o
);

    localparam int unsigned    CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 32'd1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);

    state_e             state_r;
    state_e             state_next_s;
    logic [CW-1:0]      cnt_r;
    logic               cnt_last_s;
    logic               req_fire_s;
    logic               rsp_fire_s;

    logic               cyc_r;
    logic               cyc_next_s;
    logic               rsp_valid_r;
    logic               rsp_valid_next_s;
    logic               busy_r;
    logic               busy_next_s;

    logic               we_r;
    logic [WB_SW-1:0]   sel_r;
    logic [WB_AW-1:0]   adr_r;
    logic [WB_DW-1:0]   dat_r;
    logic [WB_DW-1:0]   rsp_dat_r;
    logic               rsp_err_r;

    assign req_ready  = (state_r == IDLE);
    assign req_fire_s = req_valid & req_ready;
    assign rsp_fire_s = rsp_valid_r & rsp_ready;
    // The cycle now in progress is the TIMEOUT-th strobe cycle.
    assign cnt_last_s = (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; an ack on the last allowed cycle still counts as success.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_next_s = BUS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUS: begin
                if (wbm_ack_i || cnt_last_s) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = BUS;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered flags line up with it.
    always_comb begin
        cyc_next_s       = (state_next_s == BUS);
        rsp_valid_next_s = (state_next_s == RESP);
        busy_next_s      = (state_next_s != IDLE);
    end

    // Registered control outputs.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cyc_r       <= 1'b0;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            cyc_r       <= cyc_next_s;
            rsp_valid_r <= rsp_valid_next_s;
            busy_r      <= busy_next_s;
        end
    end

    // Request capture; write data is only driven onto the bus for writes.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            we_r  <= 1'b0;
            sel_r <= '0;
            adr_r <= '0;
            dat_r <= '0;
        end else if (req_fire_s) begin
            we_r  <= req_we;
            sel_r <= req_sel;
            adr_r <= req_adr;
            dat_r <= req_we ? req_dat : {WB_DW{1'b0}};
        end
    end

    // Saturating wait counter, cleared when the response is consumed.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cnt_r <= '0;
        end else if (state_r == BUS) begin
            if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CW'(1);
            end
        end else if ((state_r == RESP) && rsp_fire_s) begin
            cnt_r <= '0;
        end
    end

    // Response capture; acks seen outside BUS never reach here.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rsp_dat_r <= '0;
            rsp_err_r <= 1'b0;
        end else if (state_r == BUS) begin
            if (wbm_ack_i) begin
                rsp_dat_r <= we_r ? {WB_DW{1'b0}} : wbm_dat_i;
                rsp_err_r <= 1'b0;
            end else if (cnt_last_s) begin
                rsp_dat_r <= '0;
                rsp_err_r <= 1'b1;
            end
        end
    end

    assign wbm_cyc_o = cyc_r;
    assign wbm_stb_o = cyc_r;
    assign wbm_we_o  = we_r;
    assign wbm_sel_o = sel_r;
    assign wbm_adr_o = adr_r;
    assign wbm_dat_o = dat_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_dat   = rsp_dat_r;
    assign rsp_err   = rsp_err_r;
    assign busy_o    = busy_r;

endmodule
